// File: rtl/codec_cmd_sequencer_if.sv
// Single-command port between the CODEC sequencer and the I2C controller unit.
interface codec_cmd_sequencer_if;
  logic       rd_en;
  logic       wr_en;
  logic [7:0] addr;
  logic [8:0] wdata;
  logic       busy;
  logic [8:0] rdata;
  logic       rdata_valid;
  logic       missed_ack;

  modport master (
    output rd_en, wr_en, addr, wdata,
    input  busy, rdata, rdata_valid, missed_ack
  );

  modport slave (
    input  rd_en, wr_en, addr, wdata,
    output busy, rdata, rdata_valid, missed_ack
  );
endinterface

// File: rtl/codec_cmd_sequencer.sv
// Walks the SSM2603 init table with per-command retry, then arbitrates software
// register reads/writes onto the single-command I2C controller port.
module codec_cmd_sequencer #(
  parameter int unsigned MAX_RETRIES   = 3,
  parameter int unsigned BUSY_TIMEOUT  = 1024,
  parameter int unsigned SETTLE_CYCLES = 4096,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                  board_clk,
  input  logic                  aresetn,
  input  logic                  start_init,
  output logic                  init_done,
  output logic                  init_error,
  output logic                  seq_busy,
  input  logic                  sw_rd,
  input  logic                  sw_wr,
  input  logic [6:0]            sw_addr,
  input  logic [8:0]            sw_wdata,
  output logic                  sw_done,
  output logic                  sw_error,
  output logic [8:0]            sw_rdata,
  output logic                  sw_overrun,
  codec_cmd_sequencer_if.master ctrl
);

  localparam logic [2:0] StIdle      = 3'd0;
  localparam logic [2:0] StIssue     = 3'd1;
  localparam logic [2:0] StWaitStart = 3'd2;
  localparam logic [2:0] StWaitDone  = 3'd3;
  localparam logic [2:0] StCheck     = 3'd4;
  localparam logic [2:0] StNext      = 3'd5;
  localparam logic [2:0] StSettle    = 3'd6;
  localparam logic [2:0] StFail      = 3'd7;

  localparam logic [7:0]       MaxRetries  = 8'(MAX_RETRIES);
  localparam logic [CNT_W-1:0] BusyLimit   = CNT_W'(BUSY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SettleLimit = CNT_W'(SETTLE_CYCLES - 1);

  function automatic logic [15:0] table_entry(input logic [3:0] idx);
    case (idx)
      4'd0:    table_entry = {7'd15, 9'h000};
      4'd1:    table_entry = {7'd6,  9'h010};
      4'd2:    table_entry = {7'd0,  9'h017};
      4'd3:    table_entry = {7'd1,  9'h017};
      4'd4:    table_entry = {7'd2,  9'h079};
      4'd5:    table_entry = {7'd3,  9'h079};
      4'd6:    table_entry = {7'd4,  9'h010};
      4'd7:    table_entry = {7'd5,  9'h000};
      4'd8:    table_entry = {7'd7,  9'h00A};
      4'd9:    table_entry = {7'd8,  9'h000};
      4'd10:   table_entry = {7'd9,  9'h001};
      default: table_entry = {7'd6,  9'h000};
    endcase
  endfunction

  // Assert asynchronously, release synchronously.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge board_clk or negedge aresetn) begin
    if (!aresetn) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  logic [2:0]       state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [7:0]       retry_q, retry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_sw_q, is_sw_d;
  logic             cmd_rd_q, cmd_rd_d;
  logic             miss_q, miss_d;
  logic [6:0]       addr_q, addr_d;
  logic [8:0]       wdata_q, wdata_d;
  logic             init_done_q, init_done_d;
  logic             init_error_q, init_error_d;
  logic             pend_q, pend_d;
  logic             pend_rd_q, pend_rd_d;
  logic [6:0]       pend_addr_q, pend_addr_d;
  logic [8:0]       pend_wdata_q, pend_wdata_d;
  logic             overrun_q, overrun_d;
  logic [8:0]       rdata_q, rdata_d;
  logic             load;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    retry_d      = retry_q;
    cnt_d        = cnt_q;
    is_sw_d      = is_sw_q;
    cmd_rd_d     = cmd_rd_q;
    miss_d       = miss_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    init_done_d  = init_done_q;
    init_error_d = init_error_q;
    pend_d       = pend_q;
    pend_rd_d    = pend_rd_q;
    pend_addr_d  = pend_addr_q;
    pend_wdata_d = pend_wdata_q;
    overrun_d    = 1'b0;
    rdata_d      = rdata_q;
    load         = 1'b0;

    if (sw_rd || sw_wr) begin
      if (pend_q) begin
        overrun_d = 1'b1;
      end else begin
        pend_d       = 1'b1;
        pend_rd_d    = !sw_wr;
        pend_addr_d  = sw_addr;
        pend_wdata_d = sw_wdata;
      end
    end

    case (state_q)
      StIdle: begin
        if (start_init) begin
          is_sw_d      = 1'b0;
          cmd_rd_d     = 1'b0;
          idx_d        = 4'd0;
          retry_d      = 8'd0;
          init_done_d  = 1'b0;
          init_error_d = 1'b0;
          load         = 1'b1;
          state_d      = StIssue;
        end else if (pend_q) begin
          is_sw_d  = 1'b1;
          cmd_rd_d = pend_rd_q;
          retry_d  = 8'd0;
          pend_d   = 1'b0;
          load     = 1'b1;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWaitStart;
      end
      StWaitStart: begin
        if (ctrl.busy)                state_d = StWaitDone;
        else if (cnt_q == BusyLimit)  state_d = StFail;
        else                          cnt_d   = cnt_q + CNT_W'(1);
      end
      StWaitDone: begin
        if (!ctrl.busy) begin
          miss_d  = ctrl.missed_ack;
          state_d = StCheck;
        end
      end
      StCheck: begin
        // Retries re-issue the latched addr/data; the sw latch may already hold a new request.
        if (miss_q) begin
          if (retry_q < MaxRetries) begin
            retry_d = retry_q + 8'd1;
            state_d = StIssue;
          end else begin
            state_d = StFail;
          end
        end else begin
          state_d = StNext;
        end
      end
      StNext: begin
        if (is_sw_q) begin
          state_d = StIdle;
        end else if (idx_q == 4'd9) begin
          cnt_d   = '0;
          state_d = StSettle;
        end else if (idx_q == 4'd11) begin
          init_done_d = 1'b1;
          state_d     = StIdle;
        end else begin
          idx_d   = idx_q + 4'd1;
          retry_d = 8'd0;
          load    = 1'b1;
          state_d = StIssue;
        end
      end
      StSettle: begin
        if (cnt_q == SettleLimit) begin
          idx_d   = 4'd10;
          retry_d = 8'd0;
          load    = 1'b1;
          state_d = StIssue;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StFail: begin
        if (!is_sw_q) init_error_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      if (is_sw_d) begin
        addr_d  = pend_addr_q;
        wdata_d = pend_wdata_q;
      end else begin
        {addr_d, wdata_d} = table_entry(idx_d);
      end
    end

    if (ctrl.rdata_valid && state_q != StIdle && is_sw_q && cmd_rd_q) rdata_d = ctrl.rdata;
  end

  always_ff @(posedge board_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      idx_q        <= 4'd0;
      retry_q      <= 8'd0;
      cnt_q        <= '0;
      is_sw_q      <= 1'b0;
      cmd_rd_q     <= 1'b0;
      miss_q       <= 1'b0;
      addr_q       <= 7'd0;
      wdata_q      <= 9'd0;
      init_done_q  <= 1'b0;
      init_error_q <= 1'b0;
      pend_q       <= 1'b0;
      pend_rd_q    <= 1'b0;
      pend_addr_q  <= 7'd0;
      pend_wdata_q <= 9'd0;
      overrun_q    <= 1'b0;
      rdata_q      <= 9'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      retry_q      <= retry_d;
      cnt_q        <= cnt_d;
      is_sw_q      <= is_sw_d;
      cmd_rd_q     <= cmd_rd_d;
      miss_q       <= miss_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      init_done_q  <= init_done_d;
      init_error_q <= init_error_d;
      pend_q       <= pend_d;
      pend_rd_q    <= pend_rd_d;
      pend_addr_q  <= pend_addr_d;
      pend_wdata_q <= pend_wdata_d;
      overrun_q    <= overrun_d;
      rdata_q      <= rdata_d;
    end
  end

  assign ctrl.wr_en = (state_q == StIssue) && !cmd_rd_q;
  assign ctrl.rd_en = (state_q == StIssue) && cmd_rd_q;
  assign ctrl.addr  = {1'b0, addr_q};
  assign ctrl.wdata = wdata_q;

  assign init_done  = init_done_q;
  assign init_error = init_error_q;
  assign seq_busy   = (state_q != StIdle);
  assign sw_done    = is_sw_q && (state_q == StNext || state_q == StFail);
  assign sw_error   = is_sw_q && (state_q == StFail);
  assign sw_rdata   = rdata_q;
  assign sw_overrun = overrun_q;

endmodule

// File: tb/tb_codec_cmd_sequencer.sv
// Scoreboard bench: a behavioural I2C controller model answers issue pulses; expected
// issues and sw completions are queued as stimulus is driven and popped on DUT output.
module tb_codec_cmd_sequencer;

  localparam int unsigned BT = 32;
  localparam int unsigned ST = 64;

  typedef struct packed {
    logic       rd;
    logic [7:0] addr;
    logic [8:0] wdata;
  } iss_t;

  typedef struct packed {
    logic       rd;
    logic       err;
    logic [8:0] rdata;
  } swr_t;

  logic       board_clk = 1'b0;
  logic       aresetn;
  logic       start_init, sw_rd, sw_wr;
  logic [6:0] sw_addr;
  logic [8:0] sw_wdata;
  logic       init_done, init_error, seq_busy, sw_done, sw_error, sw_overrun;
  logic [8:0] sw_rdata;

  codec_cmd_sequencer_if ctrl_if ();

  codec_cmd_sequencer #(
    .MAX_RETRIES  (3),
    .BUSY_TIMEOUT (BT),
    .SETTLE_CYCLES(ST),
    .CNT_W        (16)
  ) dut (
    .board_clk (board_clk),
    .aresetn   (aresetn),
    .start_init(start_init),
    .init_done (init_done),
    .init_error(init_error),
    .seq_busy  (seq_busy),
    .sw_rd     (sw_rd),
    .sw_wr     (sw_wr),
    .sw_addr   (sw_addr),
    .sw_wdata  (sw_wdata),
    .sw_done   (sw_done),
    .sw_error  (sw_error),
    .sw_rdata  (sw_rdata),
    .sw_overrun(sw_overrun),
    .ctrl      (ctrl_if)
  );

  always #10 board_clk = ~board_clk;

  int   n_checks = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   sw_done_cnt = 0;
  int   overrun_cnt = 0;
  int   issue_cyc[$];
  iss_t exp_q[$];
  swr_t sw_exp_q[$];
  iss_t e_iss;
  swr_t e_sw;

  logic [6:0] t_addr[12];
  logic [8:0] t_data[12];

  // Controller model knobs
  logic [6:0] miss_addr;
  int         miss_left;
  bit         no_busy;
  int         busy_len = 10;
  logic [8:0] model_rdata;

  always @(posedge board_clk) cyc <= cyc + 1;

  initial begin
    ctrl_if.busy        = 1'b0;
    ctrl_if.rdata       = 9'd0;
    ctrl_if.rdata_valid = 1'b0;
    ctrl_if.missed_ack  = 1'b0;
    forever begin
      @(negedge board_clk);
      if (ctrl_if.wr_en || ctrl_if.rd_en) begin
        logic m;
        logic rd;
        rd = ctrl_if.rd_en;
        m  = 1'b0;
        ctrl_if.missed_ack = 1'b0;
        if (ctrl_if.addr[6:0] == miss_addr && miss_left > 0) begin
          m = 1'b1;
          miss_left--;
        end
        if (!no_busy) begin
          ctrl_if.busy = 1'b1;
          repeat (busy_len - 1) @(negedge board_clk);
          if (rd) begin
            ctrl_if.rdata       = model_rdata;
            ctrl_if.rdata_valid = 1'b1;
          end
          @(negedge board_clk);
          ctrl_if.rdata_valid = 1'b0;
          ctrl_if.busy        = 1'b0;
          ctrl_if.missed_ack  = m;
        end
      end
    end
  end

  always @(negedge board_clk) begin
    if (ctrl_if.wr_en || ctrl_if.rd_en) begin
      issue_cyc.push_back(cyc);
      n_checks++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_issue: got rd=%0b addr=%h wdata=%h, required no issue",
                 ctrl_if.rd_en, ctrl_if.addr, ctrl_if.wdata);
      end else begin
        e_iss = exp_q.pop_front();
        if (ctrl_if.rd_en !== e_iss.rd || ctrl_if.addr !== e_iss.addr ||
            (!e_iss.rd && ctrl_if.wdata !== e_iss.wdata)) begin
          n_bad++;
          $display("FAIL issue: got rd=%0b addr=%h wdata=%h, required rd=%0b addr=%h wdata=%h",
                   ctrl_if.rd_en, ctrl_if.addr, ctrl_if.wdata, e_iss.rd, e_iss.addr, e_iss.wdata);
        end
      end
    end
    if (sw_done) begin
      sw_done_cnt++;
      n_checks++;
      if (sw_exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_sw_done: got sw_done=1, required 0");
      end else begin
        e_sw = sw_exp_q.pop_front();
        if (sw_error !== e_sw.err || (e_sw.rd && sw_rdata !== e_sw.rdata)) begin
          n_bad++;
          $display("FAIL sw_result: got err=%0b rdata=%h, required err=%0b rdata=%h",
                   sw_error, sw_rdata, e_sw.err, e_sw.rdata);
        end
      end
    end
    if (sw_overrun) overrun_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge board_clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start_init = 1'b1;
    tick(1);
    start_init = 1'b0;
  endtask

  task automatic pulse_sw(input logic rd, input logic [6:0] a, input logic [8:0] d);
    sw_rd    = rd;
    sw_wr    = !rd;
    sw_addr  = a;
    sw_wdata = d;
    tick(1);
    sw_rd = 1'b0;
    sw_wr = 1'b0;
  endtask

  task automatic push_table(input int rep_idx, input int reps);
    for (int i = 0; i < 12; i++) begin
      int n;
      n = (i == rep_idx) ? reps : 1;
      repeat (n) exp_q.push_back('{rd: 1'b0, addr: {1'b0, t_addr[i]}, wdata: t_data[i]});
    end
  endtask

  task automatic wait_init(input int bound);
    int n;
    n = 0;
    while (!(init_done || init_error) && n < bound) begin
      tick(1);
      n++;
    end
    n_checks++;
    if (!(init_done || init_error)) begin
      n_bad++;
      $display("FAIL init_wait: got no init_done/init_error, required one within %0d cycles", bound);
    end
  endtask

  task automatic wait_sw(input int target, input int bound);
    int n;
    n = 0;
    while (sw_done_cnt < target && n < bound) begin
      tick(1);
      n++;
    end
    n_checks++;
    if (sw_done_cnt < target) begin
      n_bad++;
      $display("FAIL sw_wait: got %0d sw_done pulses, required %0d", sw_done_cnt, target);
    end
  endtask

  task automatic test_reset();
    tick(3);
    n_checks++;
    if ({init_done, init_error, seq_busy, sw_done, sw_error, sw_overrun,
         ctrl_if.rd_en, ctrl_if.wr_en} !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_flags: got %b, required 00000000",
               {init_done, init_error, seq_busy, sw_done, sw_error, sw_overrun,
                ctrl_if.rd_en, ctrl_if.wr_en});
    end
    n_checks++;
    if ({sw_rdata, ctrl_if.addr, ctrl_if.wdata} !== 26'd0) begin
      n_bad++;
      $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h, required 0",
               sw_rdata, ctrl_if.addr, ctrl_if.wdata);
    end
    aresetn = 1'b1;
    tick(4);
    n_checks++;
    if (seq_busy !== 1'b0 || init_done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: got busy=%0b done=%0b, required 0 0", seq_busy, init_done);
    end
  endtask

  task automatic test_init_all_ack();
    int base;
    int gap;
    base = issue_cyc.size();
    push_table(-1, 0);
    pulse_start();
    wait_init(3000);
    n_checks++;
    if (init_done !== 1'b1 || init_error !== 1'b0) begin
      n_bad++;
      $display("FAIL init_ok_flags: got done=%0b err=%0b, required 1 0", init_done, init_error);
    end
    n_checks++;
    if (issue_cyc.size() - base != 12 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL init_ok_count: got %0d issues (%0d left), required 12 (0 left)",
               issue_cyc.size() - base, exp_q.size());
    end
    if (issue_cyc.size() - base >= 12) begin
      gap = issue_cyc[base + 10] - issue_cyc[base + 9];
      n_checks++;
      if (gap < ST + 10 || gap > ST + 16) begin
        n_bad++;
        $display("FAIL settle_gap: got %0d cycles, required %0d..%0d", gap, ST + 10, ST + 16);
      end
    end
  endtask

  task automatic test_sw_read();
    int n0;
    n0 = sw_done_cnt;
    model_rdata = 9'h00A;
    exp_q.push_back('{rd: 1'b1, addr: 8'h07, wdata: 9'h000});
    sw_exp_q.push_back('{rd: 1'b1, err: 1'b0, rdata: 9'h00A});
    pulse_sw(1'b1, 7'h07, 9'h1FF);
    wait_sw(n0 + 1, 200);
    tick(2);
    n_checks++;
    if (sw_rdata !== 9'h00A || seq_busy !== 1'b0 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL sw_read_after: got rdata=%h busy=%0b left=%0d, required 00a 0 0",
               sw_rdata, seq_busy, exp_q.size());
    end
  endtask

  task automatic test_sw_write_fail();
    int n0;
    n0 = sw_done_cnt;
    miss_addr = 7'h05;
    miss_left = 100;
    repeat (4) exp_q.push_back('{rd: 1'b0, addr: 8'h05, wdata: 9'h033});
    sw_exp_q.push_back('{rd: 1'b0, err: 1'b1, rdata: 9'h000});
    pulse_sw(1'b0, 7'h05, 9'h033);
    wait_sw(n0 + 1, 400);
    miss_left = 0;
    n_checks++;
    if (exp_q.size() != 0 || sw_rdata !== 9'h00A) begin
      n_bad++;
      $display("FAIL sw_write_fail: got left=%0d rdata=%h, required 0 00a", exp_q.size(), sw_rdata);
    end
  endtask

  task automatic test_retry();
    int base;
    base = issue_cyc.size();
    miss_addr = 7'd1;
    miss_left = 2;
    push_table(3, 3);
    pulse_start();
    wait_init(3000);
    n_checks++;
    if (init_done !== 1'b1 || init_error !== 1'b0) begin
      n_bad++;
      $display("FAIL retry_flags: got done=%0b err=%0b, required 1 0", init_done, init_error);
    end
    n_checks++;
    if (issue_cyc.size() - base != 14 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL retry_count: got %0d issues, required 14", issue_cyc.size() - base);
    end
  endtask

  task automatic test_abort();
    int base;
    base = issue_cyc.size();
    miss_addr = 7'd15;
    miss_left = 100;
    repeat (4) exp_q.push_back('{rd: 1'b0, addr: 8'h0F, wdata: 9'h000});
    pulse_start();
    wait_init(1000);
    tick(60);
    miss_left = 0;
    n_checks++;
    if (init_error !== 1'b1 || init_done !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_flags: got done=%0b err=%0b, required 0 1", init_done, init_error);
    end
    n_checks++;
    if (issue_cyc.size() - base != 4) begin
      n_bad++;
      $display("FAIL abort_count: got %0d issues, required 4", issue_cyc.size() - base);
    end
  endtask

  task automatic test_timeout();
    int base;
    int delta;
    base = issue_cyc.size();
    no_busy = 1'b1;
    exp_q.push_back('{rd: 1'b0, addr: 8'h0F, wdata: 9'h000});
    pulse_start();
    wait_init(500);
    delta = cyc - ((issue_cyc.size() > base) ? issue_cyc[base] : 0);
    tick(10);
    no_busy = 1'b0;
    n_checks++;
    if (init_error !== 1'b1 || issue_cyc.size() - base != 1) begin
      n_bad++;
      $display("FAIL timeout_flags: got err=%0b issues=%0d, required 1 1",
               init_error, issue_cyc.size() - base);
    end
    n_checks++;
    if (delta < BT + 1 || delta > BT + 3) begin
      n_bad++;
      $display("FAIL timeout_latency: got %0d cycles, required %0d..%0d", delta, BT + 1, BT + 3);
    end
  endtask

  task automatic test_overrun_during_init();
    int ov0;
    int n0;
    ov0 = overrun_cnt;
    n0  = sw_done_cnt;
    push_table(-1, 0);
    exp_q.push_back('{rd: 1'b0, addr: 8'h04, wdata: 9'h055});
    sw_exp_q.push_back('{rd: 1'b0, err: 1'b0, rdata: 9'h000});
    pulse_start();
    tick(5);
    pulse_sw(1'b0, 7'h04, 9'h055);
    tick(20);
    pulse_sw(1'b0, 7'h05, 9'h0AA);
    wait_init(3000);
    wait_sw(n0 + 1, 200);
    tick(30);
    n_checks++;
    if (init_done !== 1'b1 || overrun_cnt - ov0 != 1) begin
      n_bad++;
      $display("FAIL overrun: got done=%0b overruns=%0d, required 1 1", init_done, overrun_cnt - ov0);
    end
    n_checks++;
    if (exp_q.size() != 0 || sw_exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL overrun_drain: got %0d/%0d left, required 0/0", exp_q.size(), sw_exp_q.size());
    end
  endtask

  task automatic test_reset_mid_cmd();
    int n0;
    int n;
    n0 = sw_done_cnt;
    exp_q.push_back('{rd: 1'b0, addr: 8'h02, wdata: 9'h0F0});
    pulse_sw(1'b0, 7'h02, 9'h0F0);
    n = 0;
    while (!ctrl_if.busy && n < 50) begin
      tick(1);
      n++;
    end
    tick(3);
    #1;
    aresetn = 1'b0;
    #1;
    n_checks++;
    if ({seq_busy, init_done, sw_done, ctrl_if.wr_en} !== 4'b0000 ||
        {sw_rdata, ctrl_if.addr, ctrl_if.wdata} !== 26'd0) begin
      n_bad++;
      $display("FAIL async_reset: got busy=%0b done=%0b rdata=%h addr=%h wdata=%h, required all 0",
               seq_busy, init_done, sw_rdata, ctrl_if.addr, ctrl_if.wdata);
    end
    tick(12);
    aresetn = 1'b1;
    tick(10);
    n_checks++;
    if (sw_done_cnt != n0 || seq_busy !== 1'b0 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL reset_abandon: got sw_done=%0d busy=%0b left=%0d, required %0d 0 0",
               sw_done_cnt - n0, seq_busy, exp_q.size(), 0);
    end
  endtask

  initial begin
    aresetn     = 1'b0;
    start_init  = 1'b0;
    sw_rd       = 1'b0;
    sw_wr       = 1'b0;
    sw_addr     = 7'd0;
    sw_wdata    = 9'd0;
    no_busy     = 1'b0;
    miss_left   = 0;
    miss_addr   = 7'd0;
    model_rdata = 9'd0;
    t_addr = '{7'd15, 7'd6, 7'd0, 7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd7, 7'd8, 7'd9, 7'd6};
    t_data = '{9'h000, 9'h010, 9'h017, 9'h017, 9'h079, 9'h079,
               9'h010, 9'h000, 9'h00A, 9'h000, 9'h001, 9'h000};
    test_reset();
    test_init_all_ack();
    test_sw_read();
    test_sw_write_fail();
    test_retry();
    test_abort();
    test_timeout();
    test_overrun_during_init();
    test_reset_mid_cmd();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
